// File: rtl/debounce_capture_pio.sv
// Button/switch PIO: per-channel synchroniser, debouncer and edge capture
// behind a 4-word Avalon-MM slave with IRQ mask and a writable output port.
module debounce_capture_pio #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 2,
  parameter int IDLE_LEVEL      = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{(IDLE_LEVEL != 0)}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d, prev_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;

  logic [WIDTH-1:0] rise_s, fall_s, edge_s, clr_s;
  logic [31:0]      rd_mux_s;
  logic             wr_s, rd_s;
  logic             unused_wdata_s;

  assign wr_s           = chipselect & write;
  assign rd_s           = chipselect & read;
  assign unused_wdata_s = ^writedata;

  // Debounce: a new level is accepted only after CNT_MAX+1 consecutive differing cycles.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]    = cnt_q[i];
      stable_d[i] = stable_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = {CW{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end
    end
  end

  // Edge selection on the debounced level; unknown modes fall back to both edges.
  always_comb begin
    rise_s = stable_q & ~prev_q;
    fall_s = ~stable_q & prev_q;
    case (EDGE_MODE)
      0:       edge_s = rise_s;
      1:       edge_s = fall_s;
      default: edge_s = rise_s | fall_s;
    endcase
  end

  // Register writes; a new edge overrides a same-cycle clear.
  always_comb begin
    clr_s     = {WIDTH{1'b0}};
    irqmask_d = irqmask_q;
    out_d     = out_q;
    if (wr_s) begin
      case (address)
        2'd0:    out_d     = writedata[WIDTH-1:0];
        2'd1:    irqmask_d = writedata[WIDTH-1:0];
        2'd2:    clr_s     = writedata[WIDTH-1:0];
        default: clr_s     = {WIDTH{1'b0}};
      endcase
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    edgecap_d = (edgecap_q & ~clr_s) | edge_s;
  end

  // Read mux samples pre-write state so a combined read/write returns the old value.
  always_comb begin
    rd_mux_s = 32'h0;
    case (address)
      2'd0:    rd_mux_s[WIDTH-1:0] = stable_q;
      2'd1:    rd_mux_s[WIDTH-1:0] = irqmask_q;
      2'd2:    rd_mux_s[WIDTH-1:0] = edgecap_q;
      default: rd_mux_s[WIDTH-1:0] = sync2_q;
    endcase
    if (rd_s) begin
      readdata_d = rd_mux_s;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q    <= IDLE_VEC;
      sync2_q    <= IDLE_VEC;
      stable_q   <= IDLE_VEC;
      prev_q     <= IDLE_VEC;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
      edgecap_q  <= {WIDTH{1'b0}};
      irqmask_q  <= {WIDTH{1'b0}};
      out_q      <= {WIDTH{1'b0}};
      readdata_q <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      prev_q     <= stable_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      out_q      <= out_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edgecap_q & irqmask_q);
    end
  end

  assign out_port = out_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_debounce_capture_pio.sv
// Scoreboard bench for debounce_capture_pio: reads push expected data, a
// monitor pops and compares one cycle after each accepted read.
module tb_debounce_capture_pio;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [1:0]  in_port;
  logic [1:0]  out_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic rd_seen_q = 1'b0;

  debounce_capture_pio #(
    .WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .IDLE_LEVEL(0)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .in_port(in_port),
    .out_port(out_port), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) rd_seen_q <= chipselect & read;

  // Monitor: every accepted read yields one readdata word to compare.
  always @(negedge clk_clk) begin
    if (rd_seen_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: readdata %h with no expected entry", readdata);
      end else begin
        e = exp_q.pop_front();
        if (readdata !== e.val) begin
          errors++;
          $display("FAIL rd_addr%0d: got %h expected %h", e.addr, readdata, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] v);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back('{a, v});
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_reset_n = 1'b0; in_port = 2'b00; address = 2'd0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'h0;
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_out_port", {30'h0, out_port}, 32'h0);
    tick(); tick();
    reset_reset_n = 1'b1;
    tick();

    // 1: all registers read zero after reset
    rd(2'd0, 32'h0); rd(2'd1, 32'h0); rd(2'd2, 32'h0); rd(2'd3, 32'h0);
    chk("t1_irq", {31'h0, irq}, 32'h0);
    chk("t1_out_port", {30'h0, out_port}, 32'h0);

    // 2: ch0 rises; DATA sampled every cycle, stable flips on the 6th edge
    in_port = 2'b01; chipselect = 1'b1; read = 1'b1; address = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back('{2'd0, (i >= 7) ? 32'h1 : 32'h0});
      tick();
    end
    chipselect = 1'b0; read = 1'b0;
    rd(2'd2, 32'h1);
    rd(2'd3, 32'h1);
    chk("t2_irq_masked", {31'h0, irq}, 32'h0);

    // 3: unmask raises irq one cycle later; W1C drops it one cycle later
    wr(2'd1, 32'h1);
    chk("t3_irq_not_yet", {31'h0, irq}, 32'h0);
    tick();
    chk("t3_irq_set", {31'h0, irq}, 32'h1);
    rd(2'd1, 32'h1);
    wr(2'd2, 32'h1);
    chk("t3_irq_hold", {31'h0, irq}, 32'h1);
    tick();
    chk("t3_irq_clr", {31'h0, irq}, 32'h0);
    rd(2'd2, 32'h0);

    // 4: 3-cycle glitch on ch1 is visible on RAW only
    in_port = 2'b11; chipselect = 1'b1; read = 1'b1; address = 2'd3;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back('{2'd3, (i >= 3 && i <= 5) ? 32'h3 : 32'h1});
      tick();
      if (i == 3) in_port = 2'b01;
    end
    chipselect = 1'b0; read = 1'b0;
    rd(2'd0, 32'h1);
    rd(2'd2, 32'h0);
    chk("t4_irq", {31'h0, irq}, 32'h0);

    // 5: ch0 falling edge captured in the same cycle as a W1C -> set wins
    in_port = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1);
    chk("t5_irq", {31'h0, irq}, 32'h1);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h1;
    exp_q.push_back('{2'd2, 32'h1});
    tick();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    rd(2'd2, 32'h0);
    chk("t5_irq_clr", {31'h0, irq}, 32'h0);
    rd(2'd0, 32'h0);

    // 6: output port write, upper bits ignored, reset mid-debounce
    wr(2'd0, 32'hFFFF_FFFF);
    chk("t6_out_port", {30'h0, out_port}, 32'h3);
    rd(2'd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h3);
    in_port = 2'b10;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_irq_ch1", {31'h0, irq}, 32'h1);
    in_port = 2'b00;
    tick(); tick(); tick();
    reset_reset_n = 1'b0;
    #1;
    chk("t6_rst_out_port", {30'h0, out_port}, 32'h0);
    chk("t6_rst_readdata", readdata, 32'h0);
    chk("t6_rst_irq", {31'h0, irq}, 32'h0);
    tick(); tick();
    reset_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rd(2'd2, 32'h0);
    rd(2'd0, 32'h0);
    rd(2'd3, 32'h0);
    chk("t6_post_irq", {31'h0, irq}, 32'h0);

    tick(); tick();
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
